npu_act_unit: RTL and testbench

- Activation engine directly downstream of the NPU bus slave interface.
- Consumes the interface's registered-address write strobes (type / input) plus address and write data.
- Applies a selectable int8 activation function to 4 packed lanes per 32-bit word: serial, one lane per cycle, with input buffering.
- Returns type, result and status words on rdata_o for the interface's read data phase.

---
 rtl/npu_act_unit_pkg.sv | 28 ++
 rtl/npu_act_unit_fifo.sv | 48 ++++
 rtl/npu_act_unit.sv | 143 ++++++++++++++
 tb/tb_npu_act_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/npu_act_unit_pkg.sv
// Shared types, register offsets and the int8 activation function for the NPU activation unit.
package pkg_act;

    localparam int unsigned LeakyShift = 3;

    localparam logic [3:0] TypeOff   = 4'h0;
    localparam logic [3:0] InputOff  = 4'h4;
    localparam logic [3:0] OutputOff = 4'h8;
    localparam logic [3:0] StatusOff = 4'hC;

    typedef enum logic [1:0] {ActIdent, ActRelu, ActLeaky, ActClip} act_type_e;
    typedef enum logic [1:0] {StIdle, StCalc, StDone} act_fsm_e;

    function automatic logic [7:0] act_apply(input act_type_e op, input logic signed [7:0] x,
                                             input logic signed [7:0] clip);
        logic [7:0] r;
        r = x;
        case (op)
            ActIdent: r = x;
            ActRelu:  r = x[7] ? 8'h00 : x;
            ActLeaky: r = x[7] ? (x >>> LeakyShift) : x;
            ActClip:  r = x[7] ? 8'h00 : ((x > clip) ? clip : x);
            default:  r = x;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/npu_act_unit_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module act_fifo #(
    parameter int unsigned DWidth = 32,
    parameter int unsigned Depth  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic [DWidth-1:0]       wdata_i,
    input  logic                    pop_i,
    output logic [DWidth-1:0]       rdata_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(Depth):0]  count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [DWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]     count_q;
    logic              push_ok, pop_ok;

    assign full_o  = (count_q == (PtrW+1)'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{PtrW{1'b0}}, push_ok} - {{PtrW{1'b0}}, pop_ok};
        end
    end

endmodule

// File: rtl/npu_act_unit.sv
// NPU activation engine: buffers 32-bit words of 4 int8 lanes and applies the selected
// activation one lane per cycle; results and status are readable over the bus.
module npu_act_unit
    import pkg_act::*;
#(
    parameter int unsigned       DWidth = 32,
    parameter int unsigned       Depth  = 4,
    parameter logic signed [7:0] Clip   = 8'sd96
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wen_type_i,
    input  logic              wen_input_i,
    input  logic [DWidth-1:0] addr_i,
    input  logic [DWidth-1:0] wdata_i,
    output logic [DWidth-1:0] rdata_o,
    output logic              busy_o
);

    localparam int unsigned CntW = $clog2(Depth) + 1;

    act_fsm_e          state_q, state_d;
    act_type_e         type_q, op_q;
    logic [3:0]        addr_q;
    logic              wt_q, wi_q;
    logic [DWidth-1:0] sh_q, res_q, out_q;
    logic [1:0]        lane_cnt_q;
    logic              out_valid_q, overflow_q;
    logic [7:0]        done_cnt_q;

    logic              pop;
    logic              fifo_full, fifo_empty;
    logic [DWidth-1:0] fifo_rdata;
    logic [CntW-1:0]   fifo_count;
    logic              drop;

    // Only the register offset is decoded.
    logic unused_addr;
    assign unused_addr = ^addr_i[DWidth-1:4];

    act_fifo #(
        .DWidth (DWidth),
        .Depth  (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (wi_q),
        .wdata_i (wdata_i),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign drop   = wi_q && fifo_full && !pop;
    assign busy_o = (state_q != StIdle) || !fifo_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= StIdle;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!fifo_empty) state_d = StCalc;
            StCalc:  if (lane_cnt_q == 2'd3) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pop = (state_q == StIdle) && !fifo_empty;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
            wt_q   <= 1'b0;
            wi_q   <= 1'b0;
        end else begin
            addr_q <= addr_i[3:0];
            wt_q   <= wen_type_i;
            wi_q   <= wen_input_i;
        end
    end

    // Lanes are consumed from the bottom of sh_q, which shifts right once per lane.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q       <= '0;
            op_q       <= ActIdent;
            lane_cnt_q <= '0;
            res_q      <= '0;
        end else if (pop) begin
            sh_q       <= fifo_rdata;
            op_q       <= type_q;
            lane_cnt_q <= '0;
        end else if (state_q == StCalc) begin
            res_q[{lane_cnt_q, 3'b000} +: 8] <= act_apply(op_q, sh_q[7:0], Clip);
            sh_q       <= sh_q >> 8;
            lane_cnt_q <= lane_cnt_q + 2'd1;
        end
    end

    // A completing word and a drop take precedence over a same-cycle TYPE clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            type_q      <= ActIdent;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            if (wt_q) begin
                type_q      <= act_type_e'(wdata_i[1:0]);
                out_valid_q <= 1'b0;
                overflow_q  <= 1'b0;
            end
            if (drop) overflow_q <= 1'b1;
            if (state_q == StDone) begin
                out_q       <= res_q;
                out_valid_q <= 1'b1;
                done_cnt_q  <= done_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        case (addr_q)
            TypeOff:   rdata_o = DWidth'(type_q);
            InputOff:  rdata_o = '0;
            OutputOff: rdata_o = out_q;
            StatusOff: rdata_o = DWidth'({16'b0, done_cnt_q, 1'b0, overflow_q, out_valid_q,
                                          busy_o, 4'(fifo_count)});
            default:   rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_npu_act_unit.sv
// Scoreboard bench for npu_act_unit: expected words are queued at INPUT writes and
// compared when the status register shows a new completion.
module tb_npu_act_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wen_type = 1'b0;
    logic        wen_input = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        busy;

    int          n_checks = 0;
    int          n_fail = 0;
    int          model_type = 0;
    logic [7:0]  last_done = '0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    npu_act_unit #(
        .DWidth (32),
        .Depth  (4),
        .Clip   (8'sd96)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .wen_type_i  (wen_type),
        .wen_input_i (wen_input),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .rdata_o     (rdata),
        .busy_o      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int op, input logic [31:0] w);
        logic [31:0] r;
        logic [7:0]  b;
        int          x, y;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            b = w[8*i +: 8];
            x = int'($signed(b));
            case (op)
                1:       y = (x < 0) ? 0 : x;
                2:       y = (x < 0) ? (x - 7) / 8 : x;
                3:       y = (x < 0) ? 0 : ((x > 96) ? 96 : x);
                default: y = x;
            endcase
            r[8*i +: 8] = y[7:0];
        end
        return r;
    endfunction

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a;
        @(posedge clk);
        #1 d = rdata;
    endtask

    task automatic bus_write(input bit is_type, input logic [31:0] d);
        @(negedge clk);
        addr      = is_type ? 32'h0 : 32'h4;
        wen_type  = is_type;
        wen_input = !is_type;
        @(negedge clk);
        wen_type  = 1'b0;
        wen_input = 1'b0;
        wdata     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic write_type(input int t);
        bus_write(1'b1, 32'(t));
        model_type = t;
    endtask

    task automatic write_input(input logic [31:0] w);
        bus_write(1'b0, w);
        exp_q.push_back(model_word(model_type, w));
    endtask

    task automatic wait_results(input int n, input int budget);
        int          got = 0;
        int          cyc = 0;
        logic [31:0] st, o;
        while (got < n && cyc < budget) begin
            bus_read(32'hC, st);
            cyc++;
            if (st[15:8] != last_done) begin
                check_eq("done_step", {24'b0, st[15:8]}, {24'b0, last_done + 8'd1});
                last_done = st[15:8];
                bus_read(32'h8, o);
                cyc++;
                check_eq("result_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_q.size() > 0) check_eq("result", o, exp_q.pop_front());
                got++;
            end
        end
        if (got < n) check_eq("result_timeout", 32'(got), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] st, o;
        logic [31:0] words [6];
        logic [7:0]  base;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        #1 check_eq("reset_busy", {31'b0, busy}, 32'd0);
        bus_read(32'h0, o);  check_eq("reset_type", o, 32'h0);
        bus_read(32'h8, o);  check_eq("reset_out", o, 32'h0);
        bus_read(32'hC, st); check_eq("reset_status", st, 32'h0);

        // ReLU word with exact completion latency
        write_type(1);
        write_input(32'h80FF7F05);
        for (int i = 1; i <= 6; i++) begin
            bus_read(32'hC, st);
            check_eq($sformatf("latency_e%0d", i), {24'b0, st[15:8]}, (i == 6) ? 32'd1 : 32'd0);
        end
        last_done = 8'd1;
        bus_read(32'h8, o);
        check_eq("relu_result", o, exp_q.pop_front());
        check_eq("relu_literal", o, 32'h00007F05);
        bus_read(32'hC, st);
        check_eq("status_after_one", st, 32'h00000120);

        write_type(2);
        write_input(32'h80F01005);
        wait_results(1, 40);
        bus_read(32'h8, o); check_eq("leaky_literal", o, 32'hF0FE1005);

        write_type(3);
        write_input(32'h7F802005);
        wait_results(1, 40);
        bus_read(32'h8, o); check_eq("clip_literal", o, 32'h60002005);

        // Six back-to-back pushes into a 4-deep FIFO: first one is popped, the sixth dropped
        write_type(2);
        for (int i = 0; i < 6; i++) words[i] = $urandom;
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            addr      = 32'h4;
            wen_input = (i < 6);
            if (i > 0) wdata = words[i-1];
        end
        @(negedge clk);
        wen_input = 1'b0;
        for (int i = 0; i < 5; i++) exp_q.push_back(model_word(model_type, words[i]));
        base = last_done;
        bus_read(32'hC, st);
        check_eq("overflow_set", {31'b0, st[6]}, 32'd1);
        check_eq("busy_during_burst", {31'b0, st[4]}, 32'd1);
        wait_results(5, 200);
        check_eq("done_advance", {24'b0, last_done - base}, 32'd5);
        bus_read(32'hC, st);
        check_eq("overflow_sticky", {31'b0, st[6]}, 32'd1);
        check_eq("fifo_drained", {28'b0, st[3:0]}, 32'd0);
        write_type(0);
        bus_read(32'hC, st);
        check_eq("overflow_cleared", {31'b0, st[6]}, 32'd0);
        check_eq("out_valid_cleared", {31'b0, st[5]}, 32'd0);

        // TYPE change while a ReLU word is being computed
        write_type(1);
        write_input(32'h80FF7F05);
        write_type(0);
        wait_results(1, 40);
        write_input(32'h80FF7F05);
        wait_results(1, 40);
        bus_read(32'h8, o); check_eq("ident_after_change", o, 32'h80FF7F05);

        // Reset one cycle mid-computation
        write_type(1);
        bus_write(1'b0, 32'h11223344);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("abort_busy", {31'b0, busy}, 32'd0);
        bus_read(32'hC, st); check_eq("abort_status", st, 32'h0);
        bus_read(32'h8, o);  check_eq("abort_out", o, 32'h0);
        repeat (8) @(posedge clk);
        #1 bus_read(32'hC, st); check_eq("abort_no_result", st, 32'h0);
        last_done  = '0;
        model_type = 0;
        write_type(2);
        write_input(32'h80F01005);
        wait_results(1, 40);

        check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
